sprite_motion_ctrl: RTL



---
 rtl/sprite_pkg.sv | 30 +++
 rtl/turn_buffer.sv | 44 ++++
 rtl/sprite_motion_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared direction encoding, helpers and FSM states for maze sprite motion.
package sprite_pkg;

   localparam logic [3:0] DIR_NONE = 4'b0000;
   localparam logic [3:0] DIR_L    = 4'b0001;
   localparam logic [3:0] DIR_R    = 4'b0010;
   localparam logic [3:0] DIR_U    = 4'b0100;
   localparam logic [3:0] DIR_D    = 4'b1000;

   typedef enum logic {
      STOP = 1'b0,
      MOVE = 1'b1
   } state_t;

   // Reduce a multi-hot request to one direction, L beating R beating U beating D.
   function automatic logic [3:0] dir_priority(input logic [3:0] req);
      logic [3:0] res;
      res = DIR_NONE;
      if (req[0])      res = DIR_L;
      else if (req[1]) res = DIR_R;
      else if (req[2]) res = DIR_U;
      else if (req[3]) res = DIR_D;
      return res;
   endfunction

   function automatic logic [3:0] dir_opposite(input logic [3:0] d);
      return {d[2], d[3], d[0], d[1]};
   endfunction

endpackage

// File: rtl/turn_buffer.sv
// Holds the latest turn request for HOLD_TICKS move ticks; a fresh request is
// visible on pending in the same cycle it arrives.
module turn_buffer
   import sprite_pkg::*;
#(
   parameter int HOLD_TICKS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_dir,
   input  logic       move_tick,
   input  logic       freeze,
   input  logic       consume,
   output logic [3:0] pending,
   output logic       pending_valid
);

   localparam int HW = $clog2(HOLD_TICKS + 1);

   logic [3:0]    pend_q;
   logic [HW-1:0] hold_q;
   logic [3:0]    req_p;

   assign req_p         = dir_priority(req_dir);
   assign pending       = (req_p != DIR_NONE) ? req_p : pend_q;
   assign pending_valid = (pending != DIR_NONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= DIR_NONE;
         hold_q <= '0;
      end else if (consume) begin
         pend_q <= DIR_NONE;
         hold_q <= '0;
      end else if (req_p != DIR_NONE) begin
         pend_q <= req_p;
         hold_q <= HW'(HOLD_TICKS);
      end else if (move_tick && !freeze && hold_q != '0) begin
         hold_q <= hold_q - 1'b1;
         if (hold_q == HW'(1)) pend_q <= DIR_NONE;
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Tile-aware sprite mover: position/heading FSM stepping SPEED pixels per tick,
// buffered turns taken at tile boundaries, reversals taken immediately, tunnel wrap.
module sprite_motion_ctrl
   import sprite_pkg::*;
#(
   parameter int         X_W        = 10,
   parameter int         Y_W        = 10,
   parameter int         INI_X      = 360,
   parameter int         INI_Y      = 154,
   parameter logic [3:0] INI_DIR    = 4'b0001,
   parameter int         SPEED      = 2,
   parameter int         TILE       = 8,
   parameter int         X_MIN      = 0,
   parameter int         X_MAX      = 632,
   parameter int         HOLD_TICKS = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           move_tick,
   input  logic           freeze,
   input  logic [3:0]     req_dir,
   input  logic [3:0]     legal_moves,
   output logic [X_W-1:0] pos_x,
   output logic [Y_W-1:0] pos_y,
   output logic [3:0]     dir,
   output logic           moving,
   output logic           tile_strobe
);

   localparam int TB = $clog2(TILE);

   if (SPEED <= 0 || (TILE % SPEED) != 0) begin : g_bad_speed
      $error("sprite_motion_ctrl: SPEED must divide TILE");
   end
   if (TILE < 2 || (TILE & (TILE - 1)) != 0) begin : g_bad_tile
      $error("sprite_motion_ctrl: TILE must be a power of two");
   end

   state_t         state;
   logic [3:0]     pending;
   logic           pending_valid;
   logic           consume;
   logic           active;
   logic           aligned;
   logic [3:0]     nxt_dir;
   state_t         nxt_state;
   logic           do_step;
   logic           do_wrap;
   logic [X_W-1:0] wrap_x;
   logic [X_W-1:0] step_x;
   logic [Y_W-1:0] step_y;
   logic           step_on_grid;

   turn_buffer #(.HOLD_TICKS(HOLD_TICKS)) u_buf (
      .clk           (clk),
      .rst           (rst),
      .req_dir       (req_dir),
      .move_tick     (move_tick),
      .freeze        (freeze),
      .consume       (consume),
      .pending       (pending),
      .pending_valid (pending_valid)
   );

   assign active = move_tick & ~freeze;

   // Alignment is judged on the axis of travel, so a sprite sitting off-grid on
   // the cross axis still sees every tile boundary it passes.
   assign aligned = (dir[0] | dir[1]) ? (pos_x[TB-1:0] == '0) : (pos_y[TB-1:0] == '0);

   always_comb begin
      nxt_dir   = dir;
      nxt_state = state;
      do_step   = 1'b0;
      do_wrap   = 1'b0;
      wrap_x    = pos_x;
      consume   = 1'b0;
      if (active) begin
         if (state == MOVE && dir == DIR_L && pos_x == X_W'(X_MIN)) begin
            do_wrap = 1'b1;
            wrap_x  = X_W'(X_MAX);
         end else if (state == MOVE && dir == DIR_R && pos_x == X_W'(X_MAX)) begin
            do_wrap = 1'b1;
            wrap_x  = X_W'(X_MIN);
         end else if (aligned) begin
            if (pending_valid && (pending & legal_moves) != 4'b0000) begin
               nxt_dir   = pending;
               consume   = 1'b1;
               nxt_state = MOVE;
               do_step   = 1'b1;
            end else if ((dir & legal_moves) != 4'b0000) begin
               nxt_state = MOVE;
               do_step   = 1'b1;
            end else begin
               nxt_state = STOP;
            end
         end else if (state == MOVE) begin
            if (pending == dir_opposite(dir)) begin
               nxt_dir = pending;
               consume = 1'b1;
            end
            do_step = 1'b1;
         end
      end
   end

   always_comb begin
      step_x = pos_x;
      step_y = pos_y;
      case (nxt_dir)
         DIR_L:   step_x = pos_x - X_W'(SPEED);
         DIR_R:   step_x = pos_x + X_W'(SPEED);
         DIR_U:   step_y = pos_y - Y_W'(SPEED);
         DIR_D:   step_y = pos_y + Y_W'(SPEED);
         default: ;
      endcase
      step_on_grid = (nxt_dir[0] | nxt_dir[1]) ? (step_x[TB-1:0] == '0)
                                               : (step_y[TB-1:0] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= STOP;
         pos_x       <= X_W'(INI_X);
         pos_y       <= Y_W'(INI_Y);
         dir         <= INI_DIR;
         moving      <= 1'b0;
         tile_strobe <= 1'b0;
      end else begin
         state       <= nxt_state;
         dir         <= nxt_dir;
         moving      <= (nxt_state == MOVE);
         tile_strobe <= do_step & step_on_grid;
         if (do_wrap) begin
            pos_x <= wrap_x;
         end else if (do_step) begin
            pos_x <= step_x;
            pos_y <= step_y;
         end
      end
   end

endmodule
